// File: rtl/stream_pattern_generator_if.sv
// FIFO write-port bundle between the pattern source (master) and the downstream FIFO (slave).
interface stream_pattern_generator_if #(
   parameter int unsigned DWIDTH = 24
) ();
   logic              fifo_full;
   logic [DWIDTH-1:0] fifo_data;
   logic              fifo_wrreq;

   modport master (input fifo_full, output fifo_data, output fifo_wrreq);
   modport slave  (output fifo_full, input fifo_data, input fifo_wrreq);
endinterface

// File: rtl/stream_pattern_generator.sv
// Parametrised video test-pattern source writing frames of pixels into a FIFO write port,
// with start-of-frame / end-of-line markers and back-pressure handling.
module stream_pattern_generator #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned CWIDTH   = 8,
   parameter int unsigned DWIDTH   = CHANNELS * CWIDTH,
   parameter int unsigned XW       = 11,
   parameter int unsigned BAR_W    = 16,
   parameter int unsigned SQ_LOG2  = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [XW-1:0]              width,
   input  logic [XW-1:0]              height,
   input  logic [XW-1:0]              num_frame,
   stream_pattern_generator_if.master fifo,
   output logic                       sof,
   output logic                       eol,
   output logic [XW-1:0]              frame_cnt,
   output logic                       busy,
   output logic                       done
);
   localparam int unsigned PW = 2 * XW;
   localparam int unsigned SW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [XW-1:0]   width_q, width_d, height_q, height_d, nframe_q, nframe_d;
   logic [XW-1:0]   x_q, x_d, y_q, y_d, frame_q, frame_d;
   logic [PW-1:0]   pix_q, pix_d;
   logic [2:0]      bar_q, bar_d;
   logic [SW-1:0]   sub_q, sub_d;
   logic            wr, line_end, col_end, last_frame;
   logic [2:0]      bar_on;
   logic            chk;
   logic [DWIDTH-1:0] pixel;

   assign wr         = (state_q == S_RUN) && !fifo.fifo_full;
   assign line_end   = (x_q == width_q - XW'(1));
   assign col_end    = (y_q == height_q - XW'(1));
   assign last_frame = (frame_q == nframe_q - XW'(1));
   assign bar_on     = 3'd7 - bar_q;
   assign chk        = x_q[SQ_LOG2] ^ y_q[SQ_LOG2];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         width_q  <= '0;
         height_q <= '0;
         nframe_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         frame_q  <= '0;
         pix_q    <= '0;
         bar_q    <= '0;
         sub_q    <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         width_q  <= width_d;
         height_q <= height_d;
         nframe_q <= nframe_d;
         x_q      <= x_d;
         y_q      <= y_d;
         frame_q  <= frame_d;
         pix_q    <= pix_d;
         bar_q    <= bar_d;
         sub_q    <= sub_d;
      end
   end

   // Next-state and counter update; counters move only on an accepted write.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      width_d  = width_q;
      height_d = height_q;
      nframe_d = nframe_q;
      x_d      = x_q;
      y_d      = y_q;
      frame_d  = frame_q;
      pix_d    = pix_q;
      bar_d    = bar_q;
      sub_d    = sub_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d   = mode;
               width_d  = width;
               height_d = height;
               nframe_d = num_frame;
               x_d      = '0;
               y_d      = '0;
               frame_d  = '0;
               pix_d    = '0;
               bar_d    = '0;
               sub_d    = '0;
               state_d  = (width == '0 || height == '0 || num_frame == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (wr) begin
               pix_d = pix_q + PW'(1);
               if (sub_q == SW'(BAR_W - 1)) begin
                  sub_d = '0;
                  bar_d = bar_q + 3'd1;
               end else begin
                  sub_d = sub_q + SW'(1);
               end
               if (line_end) begin
                  x_d   = '0;
                  sub_d = '0;
                  bar_d = '0;
                  if (col_end) begin
                     y_d   = '0;
                     pix_d = '0;
                     if (last_frame) state_d = S_DONE;
                     else            frame_d = frame_q + XW'(1);
                  end else begin
                     y_d = y_q + XW'(1);
                  end
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pattern generation from the live counters and latched mode.
   always_comb begin
      pixel = '0;
      case (mode_q)
         2'd0: pixel = DWIDTH'(pix_q);
         2'd1: for (int c = 0; c < int'(CHANNELS); c++) pixel[c*CWIDTH +: CWIDTH] = CWIDTH'(x_q);
         2'd2: for (int c = 0; c < int'(CHANNELS); c++) pixel[c*CWIDTH +: CWIDTH] = {CWIDTH{bar_on[2'(c % 3)]}};
         default: pixel = {DWIDTH{chk}};
      endcase
   end

   // Write strobe and markers react in the same cycle; IDLE/DONE force them low.
   always_comb begin
      fifo.fifo_wrreq = 1'b0;
      fifo.fifo_data  = '0;
      sof             = 1'b0;
      eol             = 1'b0;
      if (state_q == S_RUN) begin
         fifo.fifo_wrreq = !fifo.fifo_full;
         fifo.fifo_data  = pixel;
         sof             = (x_q == '0) && (y_q == '0);
         eol             = line_end;
      end
   end

   assign frame_cnt = frame_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_stream_pattern_generator.sv
// Bench for stream_pattern_generator: table of run configurations checked through a pixel scoreboard,
// plus hand sequences for back-pressure, reset recovery and reset/start collision.
module tb_stream_pattern_generator;
   localparam int unsigned CH = 3, CW = 8, DW = 24, XW = 11, BAR_W = 2, SQ = 3;
   localparam int MAXCYC = 3000;
   localparam int NV = 9;

   typedef struct {
      logic [1:0] mode;
      int         w, h, nf;
      bit         bp;
      int         exp_wr, exp_sof;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          sof, eol;
      logic [XW-1:0] frame;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [1:0]    mode;
   logic [XW-1:0] width, height, num_frame;
   logic          sof, eol, busy, done;
   logic [XW-1:0] frame_cnt;

   stream_pattern_generator_if #(.DWIDTH(DW)) sif ();

   stream_pattern_generator #(
      .CHANNELS(CH), .CWIDTH(CW), .DWIDTH(DW), .XW(XW), .BAR_W(BAR_W), .SQ_LOG2(SQ)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .width(width), .height(height), .num_frame(num_frame),
      .fifo(sif), .sof(sof), .eol(eol), .frame_cnt(frame_cnt),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int   total = 0, bad = 0;
   int   nwr, nsof, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
   exp_t q[$];
   vec_t vt[NV];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [1:0] m, input int x, input int y, input int w);
      logic [DW-1:0] r;
      logic [2:0]    v;
      int            bar;
      r = '0;
      case (m)
         2'd0: r = DW'(y * w + x);
         2'd1: for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(x);
         2'd2: begin
            bar = (x / BAR_W) % 8;
            v   = 3'(7 - bar);
            for (int c = 0; c < 3; c++) r[c*8 +: 8] = v[2'(c % 3)] ? 8'hFF : 8'h00;
         end
         default: r = ((((x >> SQ) ^ (y >> SQ)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      endcase
      return r;
   endfunction

   // Scoreboard consumer: every write seen before the clock edge that commits it.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && sif.fifo_wrreq) begin
         check("busy_on_write", 32'(busy), 32'd1);
         check("wrreq_while_full", 32'(sif.fifo_full), 32'd0);
         check("sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("data", 32'(sif.fifo_data), 32'(e.data));
            check("sof", 32'(sof), 32'(e.sof));
            check("eol", 32'(eol), 32'(e.eol));
            check("frame_cnt", 32'(frame_cnt), 32'(e.frame));
         end
         nwr++;
         nsof += int'(sof);
         last_wr_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic push_case(input vec_t v);
      exp_t e;
      for (int f = 0; f < v.nf; f++)
         for (int y = 0; y < v.h; y++)
            for (int x = 0; x < v.w; x++) begin
               e.data  = model(v.mode, x, y, v.w);
               e.sof   = (x == 0) && (y == 0);
               e.eol   = (x == v.w - 1);
               e.frame = XW'(f);
               q.push_back(e);
            end
   endtask

   task automatic launch(input vec_t v);
      mode      = v.mode;
      width     = XW'(v.w);
      height    = XW'(v.h);
      num_frame = XW'(v.nf);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input bit bp, output int waited, output bit seen_busy);
      bit ok;
      ok = 1'b0; seen_busy = 1'b0; waited = 0;
      for (int i = 0; i < MAXCYC; i++) begin
         @(negedge clock);
         if (busy) seen_busy = 1'b1;
         if (done) begin
            ok = 1'b1; waited = i; done_cyc = cyc;
            break;
         end
         tick();
         if (bp) sif.fifo_full = ($urandom_range(0, 3) == 0);
      end
      sif.fifo_full = 1'b0;
      check("done_seen", 32'(ok), 32'd1);
      tick();
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      tick();
   endtask

   task automatic run_case(input vec_t v, input int idx);
      int waited;
      bit sb;
      q.delete(); nwr = 0; nsof = 0;
      push_case(v);
      launch(v);
      wait_done(v.bp, waited, sb);
      check($sformatf("writes[%0d]", idx), 32'(nwr), 32'(v.exp_wr));
      check($sformatf("sofs[%0d]", idx), 32'(nsof), 32'(v.exp_sof));
      check($sformatf("sb_drained[%0d]", idx), 32'(q.size()), 32'd0);
      check($sformatf("busy_seen[%0d]", idx), 32'(sb), 32'(v.exp_wr != 0));
      if (v.exp_wr == 0) check($sformatf("degen_done_latency[%0d]", idx), 32'(waited), 32'd0);
      else               check($sformatf("done_after_last[%0d]", idx), 32'(done_cyc), 32'(last_wr_cyc + 1));
   endtask

   initial begin
      int  waited;
      bit  sb;
      vec_t v;
      //            mode  w   h   nf bp exp_wr exp_sof
      vt[0] = '{2'd0,  4,  2,  1, 1'b0,   8, 1};
      vt[1] = '{2'd2, 16,  1,  1, 1'b0,  16, 1};
      vt[2] = '{2'd1,  2,  2,  3, 1'b0,  12, 3};
      vt[3] = '{2'd0,  4,  0,  1, 1'b0,   0, 0};
      vt[4] = '{2'd3, 20, 18,  1, 1'b1, 360, 1};
      vt[5] = '{2'd2, 40,  2,  2, 1'b1, 160, 2};
      vt[6] = '{2'd0,  5,  3,  2, 1'b1,  30, 2};
      vt[7] = '{2'd1,  3,  3,  0, 1'b0,   0, 0};
      vt[8] = '{2'd3,  0,  5,  2, 1'b0,   0, 0};

      reset = 1'b1; start = 1'b0; mode = '0; width = '0; height = '0; num_frame = '0;
      sif.fifo_full = 1'b0;
      nwr = 0; nsof = 0;
      repeat (3) tick();
      @(negedge clock);
      check("rst_wrreq", 32'(sif.fifo_wrreq), 32'd0);
      check("rst_data", 32'(sif.fifo_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sof_eol", {30'd0, sof, eol}, 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < NV; i++) run_case(vt[i], i);

      // Back-pressure for three cycles after the second write: strobe low, data parked at pixel 2.
      q.delete(); nwr = 0; nsof = 0;
      push_case(vt[0]);
      launch(vt[0]);
      tick();
      tick();
      sif.fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (k == 0) check("bp_writes_before", 32'(nwr), 32'd2);
         check("bp_wrreq_low", 32'(sif.fifo_wrreq), 32'd0);
         check("bp_data_held", 32'(sif.fifo_data), 32'd2);
         tick();
      end
      sif.fifo_full = 1'b0;
      wait_done(1'b0, waited, sb);
      check("bp_writes", 32'(nwr), 32'd8);
      check("bp_sb_drained", 32'(q.size()), 32'd0);

      // Reset after the fifth write: abort without a done pulse, then a clean full frame.
      q.delete(); nwr = 0; nsof = 0;
      v = vt[0];
      push_case(v);
      while (q.size() > 5) void'(q.pop_back());
      launch(v);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("rr_wrreq", 32'(sif.fifo_wrreq), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_partial_writes", 32'(nwr), 32'd5);
      for (int k = 0; k < 3; k++) begin
         check("rr_no_done", 32'(done), 32'd0);
         tick();
         @(negedge clock);
      end
      tick();
      run_case(vt[0], 100);

      // Reset and start in the same cycle: reset wins, nothing starts.
      q.delete(); nwr = 0;
      mode = 2'd0; width = 11'd4; height = 11'd2; num_frame = 11'd1;
      reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      @(negedge clock);
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_wrreq", 32'(sif.fifo_wrreq), 32'd0);
      tick();
      @(negedge clock);
      check("rs_no_done", 32'(done), 32'd0);
      check("rs_no_writes", 32'(nwr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stream_pattern_generator.md
Name: stream_pattern_generator

Overview:
- Synthesizable, parametrised video source that writes pixels into a downstream FIFO write port (fifo_full / fifo_data / fifo_wrreq) for pipeline bring-up, both in simulation and on the board.
- Generates a configurable number of frames of width x height pixels in one of four built-in patterns.
- Honours FIFO back-pressure with no lost or duplicated pixels.
- Emits start-of-frame and end-of-line markers alongside each pixel.

Parameters:
- CHANNELS, 3, colour channels per pixel.
- CWIDTH, 8, bits per channel.
- DWIDTH, CHANNELS*CWIDTH, pixel bus width; channel 0 occupies the LSBs.
- XW, 11, bit width of width, height and num_frame, and of the x, y and frame counters.
- BAR_W, 16, pixel width of one colour bar (mode 2); must be 1 or greater.
- SQ_LOG2, 3, log2 of the checkerboard square size (mode 3).

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  pattern select: 0 counter, 1 gradient, 2 colour bars, 3 checkerboard.
- width  in  XW  pixels per line.
- height  in  XW  lines per frame.
- num_frame  in  XW  frames to emit.
- fifo_full  in  1  downstream FIFO full.
- fifo_data  out  DWIDTH  pixel value.
- fifo_wrreq  out  1  write strobe.
- sof  out  1  current pixel is x=0, y=0.
- eol  out  1  current pixel is x=width-1.
- frame_cnt  out  XW  index of the current frame.
- busy  out  1  state is RUN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, latch mode, width, height and num_frame, and clear x, y, frame_cnt and the pixel index. If any latched dimension is 0, go to DONE; otherwise go to RUN.
  - RUN: emits pixels.
  - DONE: lasts exactly one cycle (done=1), then returns to IDLE.
- start while in RUN or DONE is ignored.
- Config inputs are don't-care outside the start cycle.
- Handshake:
  - fifo_wrreq = (state==RUN) && !fifo_full, combinational. This gives zero-latency reaction to fifo_full.
  - A write takes place on each rising edge where fifo_wrreq=1; counters advance only then.
  - While fifo_full=1, fifo_data, sof, eol and all counters hold.
- Counter update on each write:
  - x increments; at x=width-1, x goes to 0 and y increments.
  - At y=height-1 with x=width-1, y goes to 0, the pixel index clears and frame_cnt increments.
  - On the write of the last pixel of frame num_frame-1, the next state is DONE. frame_cnt holds its final value until the next start.
- Pixel index: 2*XW bits, increments per write, clears per frame.
- fifo_data, sof and eol are driven combinationally from the counters and the latched mode, valid whenever fifo_wrreq=1.
- Patterns:
  - Mode 0: pixel index, zero-extended or truncated to DWIDTH.
  - Mode 1: every channel = x[CWIDTH-1:0], zero-extended if XW<CWIDTH.
  - Mode 2: a bar counter of 0..7 advances every BAR_W written pixels within a line, wraps modulo 8, and clears at x=0. Channel c is all-ones if bit (c mod 3) of (7-bar) is 1, else 0.
  - Mode 3: every channel is all-ones if x[SQ_LOG2] XOR y[SQ_LOG2] is 1, else 0.
- Arithmetic: all counter comparisons use the latched XW-bit values; x and y never exceed their limits, so there is no overflow.
- Reset values:
  - state=IDLE, all counters 0, latched config 0.
  - fifo_wrreq=0, busy=0, done=0, sof=0, eol=0, fifo_data=0. IDLE forces data and markers to 0.
- Reset mid-frame: returns to IDLE on the next edge. fifo_wrreq is low from that edge on. No partial-frame completion and no done pulse.
- Simultaneous reset and start: reset wins.

Test Plan:
1. Basic run: width=4, height=2, num_frame=1, mode=0, fifo_full=0, start pulse -> eight consecutive writes with data 0..7. sof on data 0 only. eol on data 3 and 7. busy high during the 8 writes. done=1 on the cycle after the last write, then IDLE.
2. Back-pressure: same config, fifo_full=1 for 3 cycles after the 2nd write -> fifo_wrreq=0 for exactly those cycles with data held at 2. Full write sequence is still exactly 0..7, with no gaps or repeats.
3. Colour bars: CHANNELS=3, CWIDTH=8, BAR_W=2, width=16, height=1, mode=2 -> x=0,1: FFFFFF. x=2,3: FFFF00. x=4,5: FF00FF. x=14,15: 000000.
4. Multi-frame: width=2, height=2, num_frame=3, mode=1 -> 12 writes. frame_cnt is 0, 1, 2 across the frames. sof asserted 3 times. Data pattern is 000000, 010101, 000000, 010101 per frame.
5. Degenerate config: height=0, start -> no fifo_wrreq ever, done pulses on the cycle after start, busy stays 0.
6. Reset recovery: reset asserted after the 5th write of case 1, then start again -> writes restart at data 0 with sof, and complete a full 8-pixel frame.
